cond_logic: RTL and testbench

//  Conditional-execution stage directly downstream of decoALU. Holds architectural NZCV flags,

---
 rtl/cond_logic_pkg.sv | 52 +++++
 rtl/cond_logic_if.sv | 31 +++
 rtl/cond_logic_check.sv | 40 ++++
 rtl/cond_logic.sv | 84 ++++++++
 tb/tb_cond_logic.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/cond_logic_pkg.sv
// Shared encodings for the conditional-execution stage: condition codes,
// ALU control values, flag bit positions and the data-processing decode.
package arm_cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MVN = 4'b0101;
  localparam logic [3:0] ALU_ROR = 4'b1001;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ADD and SUB (CMP included) are the only ALU ops that produce meaningful C/V.
  function automatic logic alu_sets_cv(input logic [3:0] alu_ctl);
    return (alu_ctl == ALU_ADD) || (alu_ctl == ALU_SUB);
  endfunction

  function automatic logic is_cmp(input logic [1:0] op, input logic [3:0] cmd);
    return (op == OP_DP) && (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/cond_logic_if.sv
// Decode-to-commit bundle: decoALU-side inputs and gated commit outputs.
interface cond_logic_if #(
  parameter int CNT_W = 32
);
  logic             InstrValid;
  logic [3:0]       Cond;
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic [3:0]       ALUControl;
  logic             PCS;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       ALUFlags;
  logic             PCSrc;
  logic             RegWriteG;
  logic             MemWriteG;
  logic             CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCnt;
  logic [CNT_W-1:0] SkipCnt;

  modport master (
    output InstrValid, Cond, Op, Funct, ALUControl, PCS, RegWrite, MemWrite, ALUFlags,
    input  PCSrc, RegWriteG, MemWriteG, CondEx, Flags, ExecCnt, SkipCnt
  );

  modport slave (
    input  InstrValid, Cond, Op, Funct, ALUControl, PCS, RegWrite, MemWrite, ALUFlags,
    output PCSrc, RegWriteG, MemWriteG, CondEx, Flags, ExecCnt, SkipCnt
  );
endinterface

// File: rtl/cond_logic_check.sv
// Pure combinational condition evaluator: Instr[31:28] against registered NZCV.
module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
  end

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = ~z;
      CS: cond_ex = c;
      CC: cond_ex = ~c;
      MI: cond_ex = n;
      PL: cond_ex = ~n;
      VS: cond_ex = v;
      VC: cond_ex = ~v;
      HI: cond_ex = c & ~z;
      LS: cond_ex = ~c | z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = ~z & (n == v);
      LE: cond_ex = z | (n != v);
      AL: cond_ex = 1'b1;
      // NV is reserved and must never commit anything.
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV flag register, commit-enable gating and
// saturating executed/skipped instruction counters.
module cond_logic
  import arm_cond_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         reset,
  cond_logic_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       flags_reg, flags_next;
  logic [CNT_W-1:0] exec_cnt_reg, exec_cnt_next;
  logic [CNT_W-1:0] skip_cnt_reg, skip_cnt_next;

  logic       cond_ex;
  logic       commit;
  logic       skip;
  logic       no_write;
  logic [1:0] flag_w;

  cond_check u_cond_check (
    .cond    (bus.Cond),
    .flags   (flags_reg),
    .cond_ex (cond_ex)
  );

  always_comb begin
    no_write  = is_cmp(bus.Op, bus.Funct[4:1]);
    flag_w[1] = (bus.Op == OP_DP) & bus.Funct[0];
    flag_w[0] = flag_w[1] & alu_sets_cv(bus.ALUControl);
    // InstrValid is the first AND term so a bubble forces 0 even with X decode.
    commit    = bus.InstrValid & cond_ex;
    skip      = bus.InstrValid & ~cond_ex;
  end

  always_comb begin
    bus.PCSrc     = commit & bus.PCS;
    bus.RegWriteG = commit & bus.RegWrite & ~no_write;
    bus.MemWriteG = commit & bus.MemWrite;
    bus.CondEx    = cond_ex;
    bus.Flags     = flags_reg;
    bus.ExecCnt   = exec_cnt_reg;
    bus.SkipCnt   = skip_cnt_reg;
  end

  // Flag pair gi: gi=1 covers {N,Z}, gi=0 covers {C,V}.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag_pair
      always_comb begin
        flags_next[2*gi+1 -: 2] = flags_reg[2*gi+1 -: 2];
        if (commit && flag_w[gi]) begin
          flags_next[2*gi+1 -: 2] = bus.ALUFlags[2*gi+1 -: 2];
        end
      end
    end
  endgenerate

  always_comb begin
    exec_cnt_next = exec_cnt_reg;
    skip_cnt_next = skip_cnt_reg;
    if (commit && (exec_cnt_reg != CNT_MAX)) begin
      exec_cnt_next = exec_cnt_reg + CNT_ONE;
    end
    if (skip && (skip_cnt_reg != CNT_MAX)) begin
      skip_cnt_next = skip_cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg    <= 4'b0000;
      exec_cnt_reg <= '0;
      skip_cnt_reg <= '0;
    end else begin
      flags_reg    <= flags_next;
      exec_cnt_reg <= exec_cnt_next;
      skip_cnt_reg <= skip_cnt_next;
    end
  end
endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic (CNT_W=4 so counter saturation is reachable).
module tb_cond_logic;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cond_logic_if #(.CNT_W(CNT_W)) bus ();

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [3:0] cond, input logic [1:0] op,
                       input logic [5:0] funct, input logic [3:0] alu_ctl,
                       input logic pcs, input logic rw, input logic mw,
                       input logic [3:0] alu_flags);
    bus.InstrValid = valid;
    bus.Cond       = cond;
    bus.Op         = op;
    bus.Funct      = funct;
    bus.ALUControl = alu_ctl;
    bus.PCS        = pcs;
    bus.RegWrite   = rw;
    bus.MemWrite   = mw;
    bus.ALUFlags   = alu_flags;
    #1;
  endtask

  // CondEx expected for every Cond code with Flags = 0111 (N=0 Z=1 C=1 V=1), bit i = Cond i.
  logic [15:0] cond_tbl_0111;

  initial begin
    cond_tbl_0111 = 16'b0110_1010_0110_0101;

    // 1: reset
    drive(1'b0, 4'b0000, 2'b00, 6'b000000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111);
    reset = 1'b1;
    step();
    step();
    check("reset_flags", 32'(bus.Flags), 32'h0);
    check("reset_exec", 32'(bus.ExecCnt), 32'h0);
    check("reset_skip", 32'(bus.SkipCnt), 32'h0);
    check("reset_eq_condex", 32'(bus.CondEx), 32'h0);
    reset = 1'b0;
    $display("txn reset: Flags=%b Exec=%0d Skip=%0d", bus.Flags, bus.ExecCnt, bus.SkipCnt);

    // 2: SUBS AL, then EQ dependent on new Z
    drive(1'b1, 4'b1110, 2'b00, 6'b100101, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0110);
    check("subs_condex", 32'(bus.CondEx), 32'h1);
    check("subs_rwg", 32'(bus.RegWriteG), 32'h1);
    step();
    check("subs_flags", 32'(bus.Flags), 32'h6);
    $display("txn SUBS AL: Flags=%b Exec=%0d", bus.Flags, bus.ExecCnt);
    drive(1'b1, 4'b0000, 2'b00, 6'b001000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111);
    check("eq_rwg", 32'(bus.RegWriteG), 32'h1);
    step();
    check("eq_exec", 32'(bus.ExecCnt), 32'h2);
    check("eq_noS_flags_hold", 32'(bus.Flags), 32'h6);
    $display("txn ADD EQ: Flags=%b Exec=%0d", bus.Flags, bus.ExecCnt);

    // 3: CMP suppresses RegWriteG, then LT / GE branches
    drive(1'b1, 4'b1110, 2'b00, 6'b110101, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b1000);
    check("cmp_rwg", 32'(bus.RegWriteG), 32'h0);
    check("cmp_condex", 32'(bus.CondEx), 32'h1);
    step();
    check("cmp_flags", 32'(bus.Flags), 32'h8);
    $display("txn CMP AL: Flags=%b Exec=%0d", bus.Flags, bus.ExecCnt);
    drive(1'b1, 4'b1011, 2'b10, 6'b100000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
    check("blt_pcsrc", 32'(bus.PCSrc), 32'h1);
    step();
    check("blt_exec", 32'(bus.ExecCnt), 32'h4);
    $display("txn B LT: Exec=%0d Skip=%0d", bus.ExecCnt, bus.SkipCnt);
    drive(1'b1, 4'b1010, 2'b10, 6'b100000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
    check("bge_pcsrc", 32'(bus.PCSrc), 32'h0);
    step();
    check("bge_skip", 32'(bus.SkipCnt), 32'h1);
    check("bge_exec_hold", 32'(bus.ExecCnt), 32'h4);
    $display("txn B GE: Exec=%0d Skip=%0d", bus.ExecCnt, bus.SkipCnt);

    // 4: ADDS sets 0011, ANDS updates only N,Z
    drive(1'b1, 4'b1110, 2'b00, 6'b001001, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0011);
    step();
    check("adds_flags", 32'(bus.Flags), 32'h3);
    $display("txn ADDS AL: Flags=%b", bus.Flags);
    drive(1'b1, 4'b1110, 2'b00, 6'b000001, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0100);
    step();
    check("ands_flags", 32'(bus.Flags), 32'h7);
    check("ands_exec", 32'(bus.ExecCnt), 32'h6);
    $display("txn ANDS AL: Flags=%b Exec=%0d", bus.Flags, bus.ExecCnt);

    // Full condition table with Flags=0111, evaluated on bubbles
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i), 2'b00, 6'b000000, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000);
      check($sformatf("cond_tbl_%0h", i), 32'(bus.CondEx), 32'(cond_tbl_0111[i]));
      check($sformatf("cond_tbl_bubble_pcsrc_%0h", i), 32'(bus.PCSrc), 32'h0);
    end
    step();
    $display("txn cond table sweep: Exec=%0d Skip=%0d", bus.ExecCnt, bus.SkipCnt);

    // 5: STR NE with Z=1, failed SUBS, X bubble
    drive(1'b1, 4'b0001, 2'b01, 6'b011000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1010);
    check("str_ne_mwg", 32'(bus.MemWriteG), 32'h0);
    step();
    check("str_ne_flags", 32'(bus.Flags), 32'h7);
    check("str_ne_skip", 32'(bus.SkipCnt), 32'h2);
    $display("txn STR NE: Flags=%b Skip=%0d", bus.Flags, bus.SkipCnt);
    drive(1'b1, 4'b0001, 2'b00, 6'b100101, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b1001);
    step();
    check("subs_ne_flags_hold", 32'(bus.Flags), 32'h7);
    check("subs_ne_skip", 32'(bus.SkipCnt), 32'h3);
    $display("txn SUBS NE: Flags=%b Skip=%0d", bus.Flags, bus.SkipCnt);
    drive(1'b0, 4'b1110, 2'b00, 6'b100101, 4'b0001, 1'bx, 1'bx, 1'bx, 4'b0000);
    check("x_pcsrc", 32'(bus.PCSrc), 32'h0);
    check("x_rwg", 32'(bus.RegWriteG), 32'h0);
    check("x_mwg", 32'(bus.MemWriteG), 32'h0);
    step();
    check("x_exec_hold", 32'(bus.ExecCnt), 32'h6);
    check("x_skip_hold", 32'(bus.SkipCnt), 32'h3);
    check("x_flags_hold", 32'(bus.Flags), 32'h7);
    $display("txn X bubble: Flags=%b Exec=%0d Skip=%0d", bus.Flags, bus.ExecCnt, bus.SkipCnt);

    // 6: saturate ExecCnt (6 -> 15), one more stays 15
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'b1110, 2'b00, 6'b011010, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
      step();
    end
    check("exec_at_max", 32'(bus.ExecCnt), 32'hF);
    drive(1'b1, 4'b1110, 2'b00, 6'b011010, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
    step();
    check("exec_saturated", 32'(bus.ExecCnt), 32'hF);
    check("sat_skip_hold", 32'(bus.SkipCnt), 32'h3);
    $display("txn MOV AL x10: Exec=%0d Skip=%0d", bus.ExecCnt, bus.SkipCnt);

    // Reset wins over a same-cycle SUBS
    drive(1'b1, 4'b1110, 2'b00, 6'b100101, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b1111);
    reset = 1'b1;
    step();
    check("midreset_flags", 32'(bus.Flags), 32'h0);
    check("midreset_exec", 32'(bus.ExecCnt), 32'h0);
    check("midreset_skip", 32'(bus.SkipCnt), 32'h0);
    $display("txn reset+SUBS: Flags=%b Exec=%0d Skip=%0d", bus.Flags, bus.ExecCnt, bus.SkipCnt);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
